// File: rtl/axi4lite_sram_slave_if.sv
// AXI4-lite bus bundle between the core master port and the SRAM slave.
// Modports give each side its direction view of the five channels.
interface axi4lite_sram_slave_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arprot;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_awprot,
    output s_awready,
    input  s_wvalid, s_wdata, s_wstrb,
    output s_wready,
    output s_bvalid, s_bresp,
    input  s_bready,
    input  s_arvalid, s_araddr, s_arprot,
    output s_arready,
    output s_rvalid, s_rdata, s_rresp,
    input  s_rready
  );

  modport master (
    output s_awvalid, s_awaddr, s_awprot,
    input  s_awready,
    output s_wvalid, s_wdata, s_wstrb,
    input  s_wready,
    input  s_bvalid, s_bresp,
    output s_bready,
    output s_arvalid, s_araddr, s_arprot,
    input  s_arready,
    input  s_rvalid, s_rdata, s_rresp,
    output s_rready
  );
endinterface

// File: rtl/axi4lite_sram_slave.sv
// AXI4-lite slave fronting a synchronous single-port SRAM.
// One transaction in flight; writes win over reads; DECERR outside range.
module axi4lite_sram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi4lite_sram_slave_if.slave  s,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_EXEC, WR_RESP,
    RD_EXEC, RD_WAIT, RD_RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  state_e      state_q, state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs, in_range;
  logic unused_bits;

  assign unused_bits = ^{s.s_awprot, s.s_arprot, addr_q[1:0]};

  assign s.s_awready = resetn && !aw_held_q &&
                       (state_q == IDLE || state_q == WR_COLLECT);
  assign s.s_wready  = resetn && !w_held_q &&
                       (state_q == IDLE || state_q == WR_COLLECT);
  assign s.s_arready = resetn && state_q == IDLE &&
                       !s.s_awvalid && !s.s_wvalid;
  assign s.s_bvalid  = resetn && state_q == WR_RESP;
  assign s.s_rvalid  = resetn && state_q == RD_RESP;
  assign s.s_bresp   = bresp_q;
  assign s.s_rresp   = rresp_q;
  assign s.s_rdata   = rdata_q;

  assign aw_hs = s.s_awvalid && s.s_awready;
  assign w_hs  = s.s_wvalid && s.s_wready;
  assign ar_hs = s.s_arvalid && s.s_arready;

  assign in_range   = (addr_q >> (ADDR_WIDTH + 2)) == 32'd0;
  assign sram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign sram_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    sram_en   = 1'b0;
    sram_we   = 4'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = s.s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s.s_wdata;
      wstrb_d  = s.s_wstrb;
    end
    if (ar_hs) addr_d = s.s_araddr;

    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs)      state_d = WR_EXEC;
        else if (aw_hs || w_hs) state_d = WR_COLLECT;
        else if (ar_hs)         state_d = RD_EXEC;
      end
      WR_COLLECT: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs))
          state_d = WR_EXEC;
      end
      WR_EXEC: begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        // resetn gate keeps a reset during this cycle from writing
        sram_en   = resetn && in_range;
        sram_we   = (resetn && in_range) ? wstrb_q : 4'b0;
        bresp_d   = in_range ? OKAY : DECERR;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s.s_bready) state_d = IDLE;
      end
      RD_EXEC: begin
        cnt_d = 2'd0;
        if (in_range) begin
          sram_en = resetn;
          state_d = RD_WAIT;
        end else begin
          rdata_d = 32'd0;
          rresp_d = DECERR;
          state_d = RD_RESP;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'(RD_LATENCY - 1)) begin
          rdata_d = sram_rdata;
          rresp_d = OKAY;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RD_RESP: begin
        if (s.s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= 32'd0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Directed bench for axi4lite_sram_slave with behavioural SRAM models.
// Second instance runs with RD_LATENCY=3 for the mid-read reset case.
module tb_axi4lite_sram_slave;

  logic clk = 1'b0;
  logic resetn, resetn2;
  always #5 clk = ~clk;

  axi4lite_sram_slave_if bus();
  axi4lite_sram_slave_if bus2();

  logic        sram_en1, sram_en2;
  logic [3:0]  sram_we1, sram_we2;
  logic [11:0] sram_addr1, sram_addr2;
  logic [31:0] sram_wdata1, sram_wdata2;
  logic [31:0] sram_rdata1, sram_rdata2;

  axi4lite_sram_slave #(.ADDR_WIDTH(12), .RD_LATENCY(1)) dut (
    .clk(clk), .resetn(resetn), .s(bus),
    .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
    .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
  );

  axi4lite_sram_slave #(.ADDR_WIDTH(12), .RD_LATENCY(3)) dut2 (
    .clk(clk), .resetn(resetn2), .s(bus2),
    .sram_en(sram_en2), .sram_we(sram_we2), .sram_addr(sram_addr2),
    .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2)
  );

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:4095];
  logic [31:0] rd1, rd2, p1, p2;
  int wr_cnt1 = 0;
  int wr_cnt2 = 0;

  always @(posedge clk) begin
    if (sram_en1) begin
      if (sram_we1 != 4'd0) wr_cnt1 <= wr_cnt1 + 1;
      for (int b = 0; b < 4; b++)
        if (sram_we1[b]) mem1[sram_addr1][8*b +: 8] <= sram_wdata1[8*b +: 8];
      rd1 <= mem1[sram_addr1];
    end
  end
  assign sram_rdata1 = rd1;

  always @(posedge clk) begin
    if (sram_en2) begin
      if (sram_we2 != 4'd0) wr_cnt2 <= wr_cnt2 + 1;
      for (int b = 0; b < 4; b++)
        if (sram_we2[b]) mem2[sram_addr2][8*b +: 8] <= sram_wdata2[8*b +: 8];
      rd2 <= mem2[sram_addr2];
    end
    p1 <= rd2;
    p2 <= p1;
  end
  assign sram_rdata2 = p2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awprot = 0;
    bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0;
    bus.s_bready = 1; bus.s_arvalid = 0; bus.s_araddr = 0;
    bus.s_arprot = 0; bus.s_rready = 1;
    bus2.s_awvalid = 0; bus2.s_awaddr = 0; bus2.s_awprot = 0;
    bus2.s_wvalid = 0; bus2.s_wdata = 0; bus2.s_wstrb = 0;
    bus2.s_bready = 1; bus2.s_arvalid = 0; bus2.s_araddr = 0;
    bus2.s_arprot = 0; bus2.s_rready = 1;
  endtask

  // AW+W in cycle 0; strobe expected in cycle 1, B in cycle 2
  task automatic do_write(input string t, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st,
                          input logic en, input logic [1:0] resp);
    step();
    bus.s_awvalid = 1; bus.s_awaddr = a;
    bus.s_wvalid = 1; bus.s_wdata = d; bus.s_wstrb = st;
    smp();
    chk({t, "_awrdy"}, bus.s_awready, 1);
    chk({t, "_wrdy"}, bus.s_wready, 1);
    step();
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    smp();
    chk({t, "_en"}, sram_en1, en);
    chk({t, "_we"}, sram_we1, en ? st : 4'd0);
    if (en) chk({t, "_addr"}, sram_addr1, a[13:2]);
    step();
    smp();
    chk({t, "_bvalid"}, bus.s_bvalid, 1);
    chk({t, "_bresp"}, bus.s_bresp, resp);
    step();
    smp();
    chk({t, "_bdone"}, bus.s_bvalid, 0);
  endtask

  // AR in cycle 0; R in cycle 3 (cycle 2 when out of range)
  task automatic do_read(input string t, input logic [31:0] a,
                         input logic [31:0] ed, input logic [1:0] er,
                         input logic inr);
    step();
    bus.s_arvalid = 1; bus.s_araddr = a;
    smp();
    chk({t, "_arrdy"}, bus.s_arready, 1);
    step();
    bus.s_arvalid = 0;
    smp();
    chk({t, "_en"}, sram_en1, inr);
    chk({t, "_we"}, sram_we1, 0);
    if (inr) begin
      step();
      smp();
      chk({t, "_early"}, bus.s_rvalid, 0);
    end
    step();
    smp();
    chk({t, "_rvalid"}, bus.s_rvalid, 1);
    chk({t, "_rdata"}, bus.s_rdata, ed);
    chk({t, "_rresp"}, bus.s_rresp, er);
    step();
    smp();
    chk({t, "_rdone"}, bus.s_rvalid, 0);
  endtask

  int wc;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = 32'd0;
      mem2[i] = 32'd0;
    end
    idle_bus();
    resetn = 0;
    resetn2 = 0;
    bus.s_arvalid = 1;
    step();
    step();
    smp();
    chk("rst_awrdy", bus.s_awready, 0);
    chk("rst_wrdy", bus.s_wready, 0);
    chk("rst_arrdy", bus.s_arready, 0);
    chk("rst_en", sram_en1, 0);
    step();
    resetn = 1; resetn2 = 1;
    bus.s_arvalid = 0;
    smp();
    chk("rst_bvalid", bus.s_bvalid, 0);
    chk("rst_rvalid", bus.s_rvalid, 0);
    chk("rst_rdata", bus.s_rdata, 0);
    chk("rst_bresp", bus.s_bresp, 0);

    do_write("w1", 32'h10, 32'hDEADBEEF, 4'hF, 1, 2'b00);
    chk("w1_mem", mem1[4], 32'hDEADBEEF);

    // split write: W in cycle 0, AW in cycle 3
    mem1[4] = 32'd0;
    wc = wr_cnt1;
    step();
    bus.s_wvalid = 1; bus.s_wdata = 32'hDEADBEEF; bus.s_wstrb = 4'hF;
    smp();
    chk("sp_wrdy", bus.s_wready, 1);
    step();
    bus.s_wvalid = 0;
    smp();
    chk("sp_wheld", bus.s_wready, 0);
    chk("sp_en1", sram_en1, 0);
    step();
    smp();
    chk("sp_en2", sram_en1, 0);
    step();
    bus.s_awvalid = 1; bus.s_awaddr = 32'h10;
    smp();
    chk("sp_awrdy", bus.s_awready, 1);
    step();
    bus.s_awvalid = 0;
    smp();
    chk("sp_en", sram_en1, 1);
    chk("sp_we", sram_we1, 4'hF);
    chk("sp_addr", sram_addr1, 12'd4);
    step();
    smp();
    chk("sp_bvalid", bus.s_bvalid, 1);
    chk("sp_wcnt", wr_cnt1 - wc, 1);
    step();
    do_read("r1", 32'h10, 32'hDEADBEEF, 2'b00, 1);

    do_write("pw", 32'h10, 32'h0000AB00, 4'h2, 1, 2'b00);
    do_read("pr", 32'h10, 32'hDEADABEF, 2'b00, 1);

    do_read("oor_r", 32'h4000, 32'd0, 2'b11, 0);
    wc = wr_cnt1;
    do_write("oor_w", 32'h4000, 32'h55AA55AA, 4'hF, 0, 2'b11);
    chk("oor_wcnt", wr_cnt1 - wc, 0);

    // AR, AW, W together: write first, AR after the B handshake
    step();
    bus.s_arvalid = 1; bus.s_araddr = 32'h8;
    bus.s_awvalid = 1; bus.s_awaddr = 32'h8;
    bus.s_wvalid = 1; bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'hF;
    bus.s_rready = 0;
    smp();
    chk("pri_arrdy0", bus.s_arready, 0);
    chk("pri_awrdy", bus.s_awready, 1);
    step();
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    smp();
    chk("pri_we", sram_we1, 4'hF);
    chk("pri_arrdy1", bus.s_arready, 0);
    step();
    smp();
    chk("pri_bvalid", bus.s_bvalid, 1);
    chk("pri_arrdy2", bus.s_arready, 0);
    step();
    smp();
    chk("pri_arrdy3", bus.s_arready, 1);
    step();
    bus.s_arvalid = 0;
    smp();
    chk("pri_ren", sram_en1, 1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("hold_rvalid", bus.s_rvalid, 1);
      chk("hold_rdata", bus.s_rdata, 32'h12345678);
      step();
    end
    bus.s_rready = 1;
    smp();
    chk("hold_last", bus.s_rvalid, 1);
    step();
    smp();
    chk("hold_done", bus.s_rvalid, 0);

    // RD_LATENCY=3 instance: reset during RD_WAIT
    mem2[3] = 32'hCAFEF00D;
    step();
    bus2.s_arvalid = 1; bus2.s_araddr = 32'hC;
    smp();
    chk("l3_arrdy", bus2.s_arready, 1);
    step();
    bus2.s_arvalid = 0;
    smp();
    chk("l3_en", sram_en2, 1);
    step();
    step();
    resetn2 = 0;
    smp();
    chk("l3_rst_arrdy", bus2.s_arready, 0);
    chk("l3_rst_rvalid", bus2.s_rvalid, 0);
    step();
    resetn2 = 1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("l3_norv", bus2.s_rvalid, 0);
      chk("l3_noen", sram_en2, 0);
      step();
    end
    smp();
    chk("l3_rst_rdata", bus2.s_rdata, 0);
    chk("l3_rst_rresp", bus2.s_rresp, 0);
    step();
    bus2.s_arvalid = 1; bus2.s_araddr = 32'hC;
    smp();
    chk("l3b_arrdy", bus2.s_arready, 1);
    step();
    bus2.s_arvalid = 0;
    for (int c = 1; c < 5; c++) begin
      smp();
      chk("l3b_early", bus2.s_rvalid, 0);
      step();
    end
    smp();
    chk("l3b_rvalid", bus2.s_rvalid, 1);
    chk("l3b_rdata", bus2.s_rdata, 32'hCAFEF00D);
    chk("l3b_rresp", bus2.s_rresp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
